rom_share_arbiter: RTL and testbench

Shares the single asynchronous-read puzzle ROM (dist_mem_gen_0, 14-bit address, 8-bit data) between two solver engines, for example a part-1 and a part-2 engine running concurrently.
- Arbitration is round-robin, one ROM read per cycle.
- A requester can lock the ROM for a contiguous burst, such as reading a whole zero-terminated line.
- Returns registered read data with a per-requester valid strobe.
- Provides per-requester grant counters for debug.

---
 rtl/rom_share_arbiter.sv | 67 ++++++
 tb/tb_rom_share_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rom_share_arbiter.sv
// rom_share_arbiter: round-robin two-port arbiter for one async ROM with lockable bursts and registered read data.
module rom_share_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int MAX_LOCK = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [31:0]       gnt_count0,
  output logic [31:0]       gnt_count1
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {FREE, HELD0, HELD1} state_t;
  state_t state, state_n;
  logic last, last_n, gnt_any;
  logic [CW-1:0] lock_cnt, cnt_n;
  always_comb begin
    gnt0 = !rst && (state == HELD0 ? req0 : state == FREE && req0 && (!req1 || last));
    gnt1 = !rst && (state == HELD1 ? req1 : state == FREE && req1 && (!req0 || !last));
    gnt_any = gnt0 | gnt1;
    rom_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    cnt_n = lock_cnt + CW'(gnt_any);
    last_n = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last;
    state_n = state;
    // a grant that brings the burst count to MAX_LOCK releases ownership regardless of lock
    if (state == FREE)
      state_n = (MAX_LOCK > 1 && gnt0 && lock0) ? HELD0 : (MAX_LOCK > 1 && gnt1 && lock1) ? HELD1 : FREE;
    else if (state == HELD0)
      state_n = (!lock0 || (gnt0 && cnt_n == CW'(MAX_LOCK))) ? FREE : HELD0;
    else if (state == HELD1)
      state_n = (!lock1 || (gnt1 && cnt_n == CW'(MAX_LOCK))) ? FREE : HELD1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FREE;
      last <= 1'b1;
      lock_cnt <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata <= '0;
      gnt_count0 <= '0;
      gnt_count1 <= '0;
    end else begin
      state <= state_n;
      last <= last_n;
      lock_cnt <= state_n == FREE ? '0 : cnt_n;
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (gnt_any) rdata <= rom_data;
      gnt_count0 <= gnt_count0 + 32'(gnt0);
      gnt_count1 <= gnt_count1 + 32'(gnt1);
    end
  end
endmodule

// File: tb/tb_rom_share_arbiter.sv
// tb_rom_share_arbiter: directed checks of arbitration, locking, forced release, latency and async reset.
module tb_rom_share_arbiter;
  logic clk, rst, req0, lock0, req1, lock1, gnt0, gnt1, rvalid0, rvalid1;
  logic [13:0] addr0, addr1, rom_addr;
  logic [7:0] rdata, rom_data;
  logic [31:0] gnt_count0, gnt_count1;
  int total = 0, bad = 0;
  logic [5:0] lk, g1e;
  logic [9:0] f1e;

  rom_share_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .lock0(lock0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data),
    .gnt_count0(gnt_count0), .gnt_count1(gnt_count1)
  );

  function automatic logic [7:0] romv(input logic [13:0] a);
    return a == 14'd0 ? 8'h76 : a == 14'd1 ? 8'h4A : a == 14'd2 ? 8'h72 : a[7:0] ^ 8'h5A;
  endfunction
  assign rom_data = romv(rom_addr);

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; req0 = 0; lock0 = 0; addr0 = '0; req1 = 0; lock1 = 0; addr1 = '0;
    #2;
    chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
    chk("rst_rv0", rvalid0, 0); chk("rst_rv1", rvalid1, 0);
    chk("rst_rdata", rdata, 0); chk("rst_addr", rom_addr, 0);
    chk("rst_cnt0", gnt_count0, 0); chk("rst_cnt1", gnt_count1, 0);
    @(negedge clk) rst = 0;
    cyc();
    // single requester, sequential reads
    req0 = 1; addr0 = 14'd0; #1;
    chk("s_gnt0", gnt0, 1); chk("s_gnt1", gnt1, 0); chk("s_addr0", rom_addr, 0);
    cyc();
    chk("s_rv0a", rvalid0, 1); chk("s_rdata0", rdata, 8'h76); chk("s_rv1", rvalid1, 0);
    addr0 = 14'd1; #1;
    chk("s_addr1", rom_addr, 1);
    cyc();
    chk("s_rdata1", rdata, 8'h4A);
    addr0 = 14'd2; #1;
    chk("s_addr2", rom_addr, 2);
    cyc();
    chk("s_rv0c", rvalid0, 1); chk("s_rdata2", rdata, 8'h72);
    req0 = 0; addr0 = 14'd9; #1;
    chk("s_idle_gnt", gnt0, 0); chk("s_idle_addr", rom_addr, 0);
    chk("s_cnt0", gnt_count0, 3); chk("s_cnt1", gnt_count1, 0);
    cyc();
    chk("s_idle_rv", rvalid0, 0); chk("s_hold_rdata", rdata, 8'h72);
    // round robin after a fresh reset
    rst = 1; #1 rst = 0; #1;
    chk("rr_cnt_clr", gnt_count0, 0);
    for (int i = 0; i < 8; i++) begin
      req0 = 1; req1 = 1; addr0 = 14'(i); addr1 = 14'(100 + i); #1;
      chk("rr_gnt0", gnt0, 32'(i % 2 == 0)); chk("rr_gnt1", gnt1, 32'(i % 2 == 1));
      chk("rr_addr", rom_addr, i % 2 == 0 ? i : 100 + i);
      cyc();
      chk("rr_rv0", rvalid0, 32'(i % 2 == 0));
      chk("rr_rdata", rdata, romv(i % 2 == 0 ? 14'(i) : 14'(100 + i)));
    end
    chk("rr_cnt0", gnt_count0, 4); chk("rr_cnt1", gnt_count1, 4);
    // lock burst: 0 holds two locked grants plus its release grant, lock1 ignored meanwhile
    lk = 6'b000011; g1e = 6'b101000;
    for (int i = 0; i < 6; i++) begin
      lock0 = lk[i]; lock1 = i < 3; #1;
      chk("lk_gnt1", gnt1, g1e[i]); chk("lk_gnt0", gnt0, !g1e[i]);
      chk("lk_onehot", gnt0 & gnt1, 0);
      cyc();
      chk("lk_rv1", rvalid1, g1e[i]);
    end
    lock0 = 0; lock1 = 0;
    // forced release at four locked grants
    f1e = 10'b1000010000;
    req0 = 1; lock0 = 1; req1 = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("fr_gnt1", gnt1, f1e[i]); chk("fr_gnt0", gnt0, !f1e[i]);
      cyc();
      chk("fr_rv0", rvalid0, !f1e[i]); chk("fr_rv1", rvalid1, f1e[i]);
    end
    lock0 = 0;
    // idle holder keeps ownership without requesting
    req0 = 1; lock0 = 1; req1 = 1; addr1 = 14'd5; #1;
    chk("ih_gnt0", gnt0, 1);
    cyc();
    chk("ih_rv0", rvalid0, 1);
    req0 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ih_gnt1", gnt1, 0); chk("ih_gnt0_idle", gnt0, 0); chk("ih_addr", rom_addr, 0);
      cyc();
      chk("ih_rv0_idle", rvalid0, 0); chk("ih_rv1_idle", rvalid1, 0);
    end
    lock0 = 0; #1;
    chk("ih_rel_gnt1", gnt1, 0);
    cyc();
    #1;
    chk("ih_after_gnt1", gnt1, 1); chk("ih_after_addr", rom_addr, 5);
    cyc();
    chk("ih_after_rv1", rvalid1, 1); chk("ih_after_rdata", rdata, romv(14'd5));
    // async reset in the middle of a requester-1 burst
    req0 = 0; req1 = 1; lock1 = 1; #1;
    chk("ar_gnt1a", gnt1, 1);
    cyc();
    #1;
    chk("ar_gnt1b", gnt1, 1);
    cyc();
    chk("ar_pending", rvalid1, 1);
    #2 rst = 1; #1;
    chk("ar_gnt1", gnt1, 0); chk("ar_rv1", rvalid1, 0); chk("ar_rdata", rdata, 0);
    chk("ar_addr", rom_addr, 0); chk("ar_cnt0", gnt_count0, 0); chk("ar_cnt1", gnt_count1, 0);
    #1 rst = 0; req0 = 1; lock1 = 0; #1;
    chk("ar_first0", gnt0, 1); chk("ar_first1", gnt1, 0);
    cyc();
    chk("ar_first_rv0", rvalid0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
